digital_pfd: RTL and testbench

Counter-based digital phase-frequency detector that sits directly downstream of the feedback frequency divider in the simple PLL. It compares rising edges of the reference clock against the divided VCO clock. Both are sampled asynchronously on a fast system clock. Each reference/feedback edge pair produces a signed phase error in system-clock cycles. The block also drives UP/DN levels, flags cycle slips, and asserts a lock indicator.

---
 rtl/digital_pfd_if.sv | 38 +++
 rtl/digital_pfd.sv | 262 ++++++++++++++++++++++++++
 tb/tb_digital_pfd.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/digital_pfd_if.sv
// Signal bundle between the PLL feedback path and the digital phase-frequency
// detector: the two clock inputs being compared and every detector output.
interface digital_pfd_if #(
    parameter int CNT_W = 16
);
    logic                    ref_in;
    logic                    fb_in;
    logic                    up;
    logic                    dn;
    logic signed [CNT_W-1:0] err;
    logic                    err_valid;
    logic                    slip;
    logic                    lock;

    // Driver side: supplies ref/fb clocks, consumes detector results.
    modport master (
        output ref_in,
        output fb_in,
        input  up,
        input  dn,
        input  err,
        input  err_valid,
        input  slip,
        input  lock
    );

    // Detector side.
    modport slave (
        input  ref_in,
        input  fb_in,
        output up,
        output dn,
        output err,
        output err_valid,
        output slip,
        output lock
    );
endinterface

// File: rtl/digital_pfd.sv
// Counter-based digital phase-frequency detector. Synchronises the reference
// and divided-VCO clocks into the system clock domain, measures the distance
// between paired rising edges as a signed cycle count, drives UP/DN levels,
// flags cycle slips and tracks lock over consecutive small-error measurements.
module digital_pfd #(
    parameter int CNT_W    = 16,
    parameter int LOCK_TOL = 2,
    parameter int LOCK_N   = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    digital_pfd_if.slave pfd
);

    localparam int LC_W = $clog2(LOCK_N + 1);

    // Counter magnitude is one bit narrower than err so that both +max and
    // -max fit; -2^(CNT_W-1) is therefore never produced.
    localparam logic [CNT_W-2:0] CNT_MAX    = {(CNT_W-1){1'b1}};
    localparam logic [CNT_W-2:0] CNT_ONE    = {{(CNT_W-2){1'b0}}, 1'b1};
    localparam logic [CNT_W-2:0] CNT_ZERO   = {(CNT_W-1){1'b0}};
    localparam logic [CNT_W-2:0] TOL_C      = LOCK_TOL[CNT_W-2:0];
    localparam logic [LC_W-1:0]  LOCK_N_C   = LOCK_N[LC_W-1:0];
    localparam logic [LC_W-1:0]  LC_ONE     = {{(LC_W-1){1'b0}}, 1'b1};
    localparam logic [LC_W-1:0]  LC_ZERO    = {LC_W{1'b0}};
    localparam logic [CNT_W-1:0] ERR_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ERR_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REF_FIRST = 2'd1,
        ST_FB_FIRST  = 2'd2
    } state_t;

    // Counter increment that sticks at the maximum instead of wrapping.
    function automatic logic [CNT_W-2:0] sat_inc(input logic [CNT_W-2:0] v);
        logic [CNT_W-2:0] res;
        if (v == CNT_MAX) begin
            res = v;
        end else begin
            res = v + CNT_ONE;
        end
        return res;
    endfunction

    // Two's complement signed error from a magnitude and a direction flag.
    function automatic logic [CNT_W-1:0] signed_err(input logic [CNT_W-2:0] mag,
                                                    input logic             neg);
        logic [CNT_W-1:0] ext;
        logic [CNT_W-1:0] res;
        ext = {1'b0, mag};
        if (neg) begin
            res = ~ext + ERR_ONE;
        end else begin
            res = ext;
        end
        return res;
    endfunction

    // Synchroniser and edge-detect registers
    logic r_ref_s1, r_ref_s2, r_ref_d, r_ref_e;
    logic r_fb_s1,  r_fb_s2,  r_fb_d,  r_fb_e;

    // FSM and datapath registers
    state_t           r_state;
    logic [CNT_W-2:0] r_cnt;
    logic [LC_W-1:0]  r_lock_cnt;

    // Registered outputs
    logic             r_up;
    logic             r_dn;
    logic [CNT_W-1:0] r_err;
    logic             r_err_valid;
    logic             r_slip;
    logic             r_lock;

    // Combinational next values
    state_t           w_state_next;
    logic [CNT_W-2:0] w_cnt_next;
    logic             w_emit;
    logic [CNT_W-2:0] w_mag;
    logic             w_neg;
    logic             w_slip;
    logic [LC_W-1:0]  w_lock_cnt_next;
    logic [CNT_W-1:0] w_err_val;

    // Two-flop synchronisers plus registered rising-edge detectors for both inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref_s1 <= 1'b0;
            r_ref_s2 <= 1'b0;
            r_ref_d  <= 1'b0;
            r_ref_e  <= 1'b0;
            r_fb_s1  <= 1'b0;
            r_fb_s2  <= 1'b0;
            r_fb_d   <= 1'b0;
            r_fb_e   <= 1'b0;
        end else begin
            r_ref_s1 <= pfd.ref_in;
            r_ref_s2 <= r_ref_s1;
            r_ref_d  <= r_ref_s2;
            r_ref_e  <= r_ref_s2 & ~r_ref_d;
            r_fb_s1  <= pfd.fb_in;
            r_fb_s2  <= r_fb_s1;
            r_fb_d   <= r_fb_s2;
            r_fb_e   <= r_fb_s2 & ~r_fb_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state: which edge is waiting for its partner.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_ref_e && !r_fb_e) begin
                    w_state_next = ST_REF_FIRST;
                end else if (r_fb_e && !r_ref_e) begin
                    w_state_next = ST_FB_FIRST;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_REF_FIRST: begin
                if (r_fb_e) begin
                    // A coincident new reference edge opens the next measurement.
                    w_state_next = r_ref_e ? ST_REF_FIRST : ST_IDLE;
                end else begin
                    w_state_next = ST_REF_FIRST;
                end
            end
            ST_FB_FIRST: begin
                if (r_ref_e) begin
                    w_state_next = r_fb_e ? ST_FB_FIRST : ST_IDLE;
                end else begin
                    w_state_next = ST_FB_FIRST;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: counter update, measurement emission and slip detection.
    always_comb begin
        w_cnt_next = r_cnt;
        w_emit     = 1'b0;
        w_mag      = CNT_ZERO;
        w_neg      = 1'b0;
        w_slip     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_ref_e && r_fb_e) begin
                    w_emit     = 1'b1;
                    w_cnt_next = CNT_ZERO;
                end else if (r_ref_e || r_fb_e) begin
                    w_cnt_next = CNT_ONE;
                end else begin
                    w_cnt_next = CNT_ZERO;
                end
            end
            ST_REF_FIRST: begin
                if (r_fb_e) begin
                    w_emit     = 1'b1;
                    w_mag      = r_cnt;
                    w_cnt_next = r_ref_e ? CNT_ONE : CNT_ZERO;
                end else if (r_ref_e) begin
                    // Second reference edge with no feedback: slipped a cycle,
                    // keep timing against the original edge.
                    w_slip     = 1'b1;
                    w_cnt_next = sat_inc(r_cnt);
                end else begin
                    w_cnt_next = sat_inc(r_cnt);
                end
            end
            ST_FB_FIRST: begin
                if (r_ref_e) begin
                    w_emit     = 1'b1;
                    w_mag      = r_cnt;
                    w_neg      = 1'b1;
                    w_cnt_next = r_fb_e ? CNT_ONE : CNT_ZERO;
                end else if (r_fb_e) begin
                    w_slip     = 1'b1;
                    w_cnt_next = sat_inc(r_cnt);
                end else begin
                    w_cnt_next = sat_inc(r_cnt);
                end
            end
            default: begin
                w_cnt_next = CNT_ZERO;
            end
        endcase
    end

    // Signed error value for the measurement being emitted this cycle.
    always_comb begin
        w_err_val = signed_err(w_mag, w_neg);
    end

    // Lock counter next value: grows on in-tolerance results, clears otherwise or on slip.
    always_comb begin
        w_lock_cnt_next = r_lock_cnt;
        if (w_slip) begin
            w_lock_cnt_next = LC_ZERO;
        end else if (w_emit) begin
            if (w_mag <= TOL_C) begin
                w_lock_cnt_next = (r_lock_cnt == LOCK_N_C) ? LOCK_N_C : (r_lock_cnt + LC_ONE);
            end else begin
                w_lock_cnt_next = LC_ZERO;
            end
        end else begin
            w_lock_cnt_next = r_lock_cnt;
        end
    end

    // Datapath registers: counter and lock counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= CNT_ZERO;
            r_lock_cnt <= LC_ZERO;
        end else begin
            r_cnt      <= w_cnt_next;
            r_lock_cnt <= w_lock_cnt_next;
        end
    end

    // Output registers; err holds its last value between err_valid pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_up        <= 1'b0;
            r_dn        <= 1'b0;
            r_err       <= ERR_ZERO;
            r_err_valid <= 1'b0;
            r_slip      <= 1'b0;
            r_lock      <= 1'b0;
        end else begin
            r_up        <= (w_state_next == ST_REF_FIRST);
            r_dn        <= (w_state_next == ST_FB_FIRST);
            r_err       <= w_emit ? w_err_val : r_err;
            r_err_valid <= w_emit;
            r_slip      <= w_slip;
            r_lock      <= (r_lock_cnt == LOCK_N_C);
        end
    end

    assign pfd.up        = r_up;
    assign pfd.dn        = r_dn;
    assign pfd.err       = r_err;
    assign pfd.err_valid = r_err_valid;
    assign pfd.slip      = r_slip;
    assign pfd.lock      = r_lock;

endmodule

// File: tb/tb_digital_pfd.sv
// Self-checking bench for digital_pfd: expected errors are queued when edge
// pairs are driven and compared by a monitor whenever err_valid pulses.
module tb_digital_pfd;

    localparam int CNT_W    = 4;
    localparam int LOCK_TOL = 2;
    localparam int LOCK_N   = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    digital_pfd_if #(.CNT_W(CNT_W)) pfd_if ();

    digital_pfd #(
        .CNT_W    (CNT_W),
        .LOCK_TOL (LOCK_TOL),
        .LOCK_N   (LOCK_N)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pfd   (pfd_if)
    );

    int n_pass  = 0;
    int n_total = 0;
    int exp_q[$];
    int ev_seen   = 0;
    int up_seen   = 0;
    int dn_seen   = 0;
    int slip_seen = 0;

    // Monitor: scoreboard compare on every err_valid, plus activity counters.
    always @(negedge clk) begin
        logic signed [CNT_W-1:0] err_s;
        int expv;
        if (pfd_if.up)   up_seen++;
        if (pfd_if.dn)   dn_seen++;
        if (pfd_if.slip) slip_seen++;
        if (pfd_if.err_valid) begin
            ev_seen++;
            err_s = pfd_if.err;
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_err_valid: err=%0d, required no err_valid", int'(err_s));
            end else begin
                expv = exp_q.pop_front();
                if (int'(err_s) !== expv) begin
                    $display("FAIL err_value: err=%0d, required %0d", int'(err_s), expv);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic test_reset();
        rst_n = 1'b0;
        pfd_if.ref_in = 1'b0;
        pfd_if.fb_in  = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({pfd_if.up, pfd_if.dn, pfd_if.err_valid, pfd_if.slip, pfd_if.lock} !== 5'b00000) begin
            $display("FAIL reset_flags: up/dn/ev/slip/lock=%b, required 00000",
                     {pfd_if.up, pfd_if.dn, pfd_if.err_valid, pfd_if.slip, pfd_if.lock});
        end else begin
            n_pass++;
        end
        n_total++;
        if (pfd_if.err !== 4'd0) begin
            $display("FAIL reset_err: err=%0d, required 0", pfd_if.err);
        end else begin
            n_pass++;
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Drive ref rising at cycle dr and fb at cycle df; checks latency, up/dn, slip.
    task automatic measure(input int dr, input int df, output logic lk_ev, output logic lk_after);
        int mx;
        int u0, d0, s0, e0;
        int exp_up, exp_dn;
        mx = (dr > df) ? dr : df;
        exp_up = (df > dr) ? (df - dr) : 0;
        exp_dn = (dr > df) ? (dr - df) : 0;
        u0 = up_seen; d0 = dn_seen; s0 = slip_seen; e0 = ev_seen;
        lk_ev = 1'b0;
        lk_after = 1'b0;
        exp_q.push_back(df - dr);
        for (int t = 0; t <= mx + 5; t++) begin
            @(negedge clk);
            if (t == dr) pfd_if.ref_in = 1'b1;
            if (t == df) pfd_if.fb_in  = 1'b1;
            if (t == mx + 3) begin
                n_total++;
                if (pfd_if.err_valid !== 1'b0) begin
                    $display("FAIL ev_early(%0d,%0d): err_valid=%b, required 0", dr, df, pfd_if.err_valid);
                end else begin
                    n_pass++;
                end
            end
            if (t == mx + 4) begin
                n_total++;
                if (pfd_if.err_valid !== 1'b1) begin
                    $display("FAIL ev_latency(%0d,%0d): err_valid=%b, required 1", dr, df, pfd_if.err_valid);
                end else begin
                    n_pass++;
                end
                lk_ev = pfd_if.lock;
            end
            if (t == mx + 5) begin
                lk_after = pfd_if.lock;
                pfd_if.ref_in = 1'b0;
                pfd_if.fb_in  = 1'b0;
            end
        end
        repeat (3) @(negedge clk);
        #1;
        n_total++;
        if ((up_seen - u0) !== exp_up || (dn_seen - d0) !== exp_dn) begin
            $display("FAIL updn_cycles(%0d,%0d): up=%0d dn=%0d, required up=%0d dn=%0d",
                     dr, df, up_seen - u0, dn_seen - d0, exp_up, exp_dn);
        end else begin
            n_pass++;
        end
        n_total++;
        if ((slip_seen - s0) !== 0 || (ev_seen - e0) !== 1) begin
            $display("FAIL slip_ev_count(%0d,%0d): slips=%0d evs=%0d, required 0 and 1",
                     dr, df, slip_seen - s0, ev_seen - e0);
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_simultaneous();
        logic a, b;
        measure(0, 0, a, b);
    endtask

    task automatic test_ref_leads();
        logic a, b;
        measure(0, 5, a, b);
    endtask

    task automatic test_fb_leads_lock();
        logic lk_ev, lk_after;
        for (int i = 0; i < 8; i++) begin
            measure(1, 0, lk_ev, lk_after);
            n_total++;
            if (lk_after !== (i == 7)) begin
                $display("FAIL lock_rise[%0d]: lock=%b, required %b", i, lk_after, (i == 7));
            end else begin
                n_pass++;
            end
            if (i == 7) begin
                n_total++;
                if (lk_ev !== 1'b0) begin
                    $display("FAIL lock_early: lock=%b at err_valid, required 0", lk_ev);
                end else begin
                    n_pass++;
                end
            end
        end
        measure(0, 3, lk_ev, lk_after);
        n_total++;
        if (lk_ev !== 1'b1 || lk_after !== 1'b0) begin
            $display("FAIL lock_drop: lock at/after ev=%b/%b, required 1/0", lk_ev, lk_after);
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_slip_sat();
        int u0, d0, s0, e0;
        u0 = up_seen; d0 = dn_seen; s0 = slip_seen; e0 = ev_seen;
        exp_q.push_back(7);
        for (int t = 0; t <= 22; t++) begin
            @(negedge clk);
            pfd_if.ref_in = (t < 10) && ((t % 4) < 2);
            pfd_if.fb_in  = (t >= 14) && (t < 20);
            if (t == 17 || t == 18) begin
                n_total++;
                if (pfd_if.err_valid !== (t == 18)) begin
                    $display("FAIL slip_ev_timing t=%0d: err_valid=%b, required %b", t, pfd_if.err_valid, (t == 18));
                end else begin
                    n_pass++;
                end
            end
        end
        repeat (3) @(negedge clk);
        #1;
        n_total++;
        if ((slip_seen - s0) !== 2) begin
            $display("FAIL slip_count: slips=%0d, required 2", slip_seen - s0);
        end else begin
            n_pass++;
        end
        n_total++;
        if ((up_seen - u0) !== 14 || (dn_seen - d0) !== 0 || (ev_seen - e0) !== 1) begin
            $display("FAIL slip_updn: up=%0d dn=%0d evs=%0d, required 14 0 1",
                     up_seen - u0, dn_seen - d0, ev_seen - e0);
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int u0, d0, e0;
        u0 = up_seen; d0 = dn_seen; e0 = ev_seen;
        exp_q.push_back(4);
        exp_q.push_back(6);
        for (int t = 0; t <= 17; t++) begin
            @(negedge clk);
            pfd_if.ref_in = (t == 0) || (t == 1) || (t == 4) || (t == 5);
            pfd_if.fb_in  = (t == 4) || (t == 5) || (t == 10) || (t == 11);
            if (t == 8 || t == 9 || t == 14) begin
                n_total++;
                if (pfd_if.err_valid !== (t != 9)) begin
                    $display("FAIL b2b_ev t=%0d: err_valid=%b, required %b", t, pfd_if.err_valid, (t != 9));
                end else begin
                    n_pass++;
                end
            end
            if (t == 8) begin
                n_total++;
                if (pfd_if.up !== 1'b1) begin
                    $display("FAIL b2b_up_held: up=%b, required 1", pfd_if.up);
                end else begin
                    n_pass++;
                end
            end
        end
        repeat (3) @(negedge clk);
        #1;
        n_total++;
        if ((up_seen - u0) !== 10 || (dn_seen - d0) !== 0 || (ev_seen - e0) !== 2) begin
            $display("FAIL b2b_counts: up=%0d dn=%0d evs=%0d, required 10 0 2",
                     up_seen - u0, dn_seen - d0, ev_seen - e0);
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int e0;
        logic a, b;
        for (int t = 0; t <= 7; t++) begin
            @(negedge clk);
            pfd_if.fb_in = (t < 7);
        end
        n_total++;
        if (pfd_if.dn !== 1'b1) begin
            $display("FAIL rstmid_dn_before: dn=%b, required 1", pfd_if.dn);
        end else begin
            n_pass++;
        end
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({pfd_if.up, pfd_if.dn, pfd_if.err_valid, pfd_if.slip, pfd_if.lock} !== 5'b00000 ||
            pfd_if.err !== 4'd0) begin
            $display("FAIL rstmid_outputs: up/dn/ev/slip/lock=%b err=%0d, required 00000 and 0",
                     {pfd_if.up, pfd_if.dn, pfd_if.err_valid, pfd_if.slip, pfd_if.lock}, pfd_if.err);
        end else begin
            n_pass++;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        e0 = ev_seen;
        repeat (12) @(negedge clk);
        #1;
        n_total++;
        if ((ev_seen - e0) !== 0 || pfd_if.dn !== 1'b0) begin
            $display("FAIL rstmid_no_ev: evs=%0d dn=%b, required 0 and 0", ev_seen - e0, pfd_if.dn);
        end else begin
            n_pass++;
        end
        measure(2, 0, a, b);
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_ref_leads();
        test_fb_leads_lock();
        test_slip_sat();
        test_back_to_back();
        test_reset_mid();
        n_total++;
        if (exp_q.size() !== 0) begin
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", exp_q.size());
        end else begin
            n_pass++;
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
